// File: rtl/alu_seq_pkg.sv
// Shared opcode and state definitions for the ALU op sequencer slice.
// Opcode value doubles as the bit index of the unit enable it selects.
package alu_seq_pkg;

    localparam logic [1:0] OP_AND = 2'd0;
    localparam logic [1:0] OP_OR  = 2'd1;
    localparam logic [1:0] OP_NOR = 2'd2;
    localparam logic [1:0] OP_XOR = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } seq_state_t;

endpackage

// File: rtl/seq_regfile.sv
// Small register file: one write port, two operand read ports and a debug read port.
// All reads are combinational; the sequencer registers the operand reads itself.
module seq_regfile #(
    parameter int DATA_W = 4,
    parameter int NREG   = 4,
    parameter int REG_AW = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] regs [NREG];

    // One register per entry so a reset clears the whole file at once.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
        logic [DATA_W-1:0] q_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q_reg <= '0;
            end else if (we && (waddr == REG_AW'(gi))) begin
                q_reg <= wdata;
            end
        end

        assign regs[gi] = q_reg;
    end

    assign rdata1   = regs[raddr1];
    assign rdata2   = regs[raddr2];
    assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_op_sequencer.sv
// Four-phase controller (IDLE/READ/EXEC/WB) driving an external bank of enable-gated
// logic units and writing the OR-combined unit result back into its register file.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int NREG   = 4,
    parameter int REG_AW = 2,
    parameter int NOPS   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [1:0]        instr_op,
    input  logic [REG_AW-1:0] instr_rd,
    input  logic [REG_AW-1:0] instr_rs1,
    input  logic [REG_AW-1:0] instr_rs2,
    output logic [NOPS-1:0]   op_en,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    input  logic [DATA_W-1:0] op_result,
    output logic              wb_valid,
    output logic [REG_AW-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              busy,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    seq_state_t        state_reg;
    logic [1:0]        op_reg;
    logic [REG_AW-1:0] rd_reg;
    logic [REG_AW-1:0] rs1_reg;
    logic [REG_AW-1:0] rs2_reg;
    logic [NOPS-1:0]   op_en_reg;
    logic [DATA_W-1:0] op_a_reg;
    logic [DATA_W-1:0] op_b_reg;
    logic [DATA_W-1:0] result_reg;
    logic              wb_valid_reg;
    logic [REG_AW-1:0] wb_addr_reg;
    logic [DATA_W-1:0] rf_rdata1;
    logic [DATA_W-1:0] rf_rdata2;

    // The write lands at the end of WB, so the earliest following READ sees it.
    seq_regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG),
        .REG_AW (REG_AW)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (state_reg == S_WB),
        .waddr    (wb_addr_reg),
        .wdata    (result_reg),
        .raddr1   (rs1_reg),
        .raddr2   (rs2_reg),
        .rdata1   (rf_rdata1),
        .rdata2   (rf_rdata2),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            op_reg       <= '0;
            rd_reg       <= '0;
            rs1_reg      <= '0;
            rs2_reg      <= '0;
            op_en_reg    <= '0;
            op_a_reg     <= '0;
            op_b_reg     <= '0;
            result_reg   <= '0;
            wb_valid_reg <= 1'b0;
            wb_addr_reg  <= '0;
        end else begin
            wb_valid_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (instr_valid) begin
                        op_reg    <= instr_op;
                        rd_reg    <= instr_rd;
                        rs1_reg   <= instr_rs1;
                        rs2_reg   <= instr_rs2;
                        state_reg <= S_READ;
                    end
                end
                S_READ: begin
                    op_a_reg  <= rf_rdata1;
                    op_b_reg  <= rf_rdata2;
                    op_en_reg <= NOPS'(1) << op_reg;
                    state_reg <= S_EXEC;
                end
                S_EXEC: begin
                    // Result is captured and presented as the write-back in the same edge.
                    result_reg   <= op_result;
                    wb_addr_reg  <= rd_reg;
                    wb_valid_reg <= 1'b1;
                    op_en_reg    <= '0;
                    state_reg    <= S_WB;
                end
                S_WB: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign instr_ready = (state_reg == S_IDLE);
    assign busy        = (state_reg != S_IDLE);
    assign op_en       = op_en_reg;
    assign op_a        = op_a_reg;
    assign op_b        = op_b_reg;
    assign wb_valid    = wb_valid_reg;
    assign wb_addr     = wb_addr_reg;
    assign wb_data     = result_reg;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: models the external op-unit bank, keeps a transaction-level
// reference (register array + phase counter since acceptance) and compares every cycle.
module tb_alu_op_sequencer;
    import alu_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [1:0] instr_op = 2'd0;
    logic [1:0] instr_rd = 2'd0;
    logic [1:0] instr_rs1 = 2'd0;
    logic [1:0] instr_rs2 = 2'd0;
    logic [3:0] op_en;
    logic [3:0] op_a;
    logic [3:0] op_b;
    logic [3:0] op_result;
    logic       wb_valid;
    logic [1:0] wb_addr;
    logic [3:0] wb_data;
    logic       busy;
    logic [1:0] dbg_addr = 2'd0;
    logic [3:0] dbg_data;

    always #5 clk = ~clk;

    alu_op_sequencer #(
        .DATA_W (4),
        .NREG   (4),
        .REG_AW (2),
        .NOPS   (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_rd    (instr_rd),
        .instr_rs1   (instr_rs1),
        .instr_rs2   (instr_rs2),
        .op_en       (op_en),
        .op_a        (op_a),
        .op_b        (op_b),
        .op_result   (op_result),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .busy        (busy),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    // External unit bank: each unit outputs 0 unless enabled; results are OR-ed.
    always_comb begin
        op_result = 4'h0;
        if (op_en[0]) op_result = op_result | (op_a & op_b);
        if (op_en[1]) op_result = op_result | (op_a | op_b);
        if (op_en[2]) op_result = op_result | ~(op_a | op_b);
        if (op_en[3]) op_result = op_result | (op_a ^ op_b);
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference: phase = cycles since acceptance (0 = idle, 1..3 = busy, 3 = write-back).
    int         phase = 0;
    logic [3:0] mreg [4];
    logic [1:0] m_op;
    logic [1:0] m_rd;
    logic [3:0] m_a;
    logic [3:0] m_b;
    bit         accepted_now = 1'b0;

    function automatic logic [3:0] alu(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_NOR:  return ~(a | b);
            default: return a ^ b;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s timeout actual=none required=event (t=%0t)", name, $time);
    endtask

    task automatic model_update();
        accepted_now = 1'b0;
        if (!rst_n) begin
            phase = 0;
            for (int i = 0; i < 4; i++) mreg[i] = 4'h0;
        end else if (phase == 0) begin
            if (instr_valid) begin
                m_op = instr_op;
                m_rd = instr_rd;
                m_a  = mreg[instr_rs1];
                m_b  = mreg[instr_rs2];
                phase = 1;
                accepted_now = 1'b1;
            end
        end else if (phase == 3) begin
            mreg[m_rd] = alu(m_op, m_a, m_b);
            phase = 0;
        end else begin
            phase++;
        end
    endtask

    task automatic compare();
        logic [3:0] en_exp;
        if (!rst_n) return;
        en_exp = (phase == 2) ? (4'b0001 << m_op) : 4'b0000;
        chk("instr_ready", int'(instr_ready), int'(phase == 0));
        chk("busy", int'(busy), int'(phase != 0));
        chk("wb_valid", int'(wb_valid), int'(phase == 3));
        chk("op_en", int'(op_en), int'(en_exp));
        chk("op_en_onehot", int'($countones(op_en) <= 1), 1);
        chk("dbg_data", int'(dbg_data), int'(mreg[dbg_addr]));
        if (phase >= 2) begin
            chk("op_a", int'(op_a), int'(m_a));
            chk("op_b", int'(op_b), int'(m_b));
        end
        if (phase == 3) begin
            chk("wb_addr", int'(wb_addr), int'(m_rd));
            chk("wb_data", int'(wb_data), int'(alu(m_op, m_a, m_b)));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare();
        cyc++;
    endtask

    task automatic wait_accept(output int at);
        bit got = 1'b0;
        at = -1;
        for (int i = 0; i < 12 && !got; i++) begin
            step();
            got = accepted_now;
        end
        if (got) at = cyc;
        else timeout_fail("accept");
    endtask

    task automatic issue(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2, output logic [3:0] wbd, output logic [3:0] en_seen,
                         output int lat);
        int at;
        bit got = 1'b0;
        wbd = 4'h0;
        en_seen = 4'h0;
        lat = 0;
        instr_op = op;
        instr_rd = rd;
        instr_rs1 = rs1;
        instr_rs2 = rs2;
        instr_valid = 1'b1;
        wait_accept(at);
        instr_valid = 1'b0;
        if (at < 0) return;
        lat = 1;
        for (int i = 0; i < 6 && !got; i++) begin
            step();
            lat++;
            if (op_en != 4'h0) en_seen = op_en;
            got = wb_valid;
            if (got) wbd = wb_data;
        end
        if (!got) timeout_fail("wb_valid");
    endtask

    logic [3:0] wbd;
    logic [3:0] en_seen;
    int         lat;
    int         a1;
    int         a2;
    logic [3:0] sweep_exp [4];
    logic [3:0] sweep_en [4];

    initial begin
        for (int i = 0; i < 4; i++) mreg[i] = 4'h0;
        sweep_exp[0] = 4'h0; sweep_exp[1] = 4'hF; sweep_exp[2] = 4'h0; sweep_exp[3] = 4'hF;
        sweep_en[0] = 4'b0001; sweep_en[1] = 4'b0010; sweep_en[2] = 4'b0100; sweep_en[3] = 4'b1000;

        // Power-on reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("por_ready", int'(instr_ready), 1);
        chk("por_busy", int'(busy), 0);
        chk("por_op_en", int'(op_en), 0);
        chk("por_wb_valid", int'(wb_valid), 0);
        chk("por_op_a", int'(op_a), 0);
        chk("por_wb_data", int'(wb_data), 0);
        for (int a = 0; a < 4; a++) begin
            dbg_addr = 2'(a);
            #1;
            chk("por_dbg", int'(dbg_data), 0);
            step();
        end

        // Preload r3 = NOR(r0,r0) = F, then NOR r2 <- r3,r3 = 0
        issue(OP_NOR, 2'd3, 2'd0, 2'd0, wbd, en_seen, lat);
        chk("nor_r3_data", int'(wbd), 4'hF);
        chk("nor_r3_lat", lat, 3);
        issue(OP_NOR, 2'd2, 2'd3, 2'd3, wbd, en_seen, lat);
        chk("nor_r2_data", int'(wbd), 4'h0);
        chk("nor_r2_en", int'(en_seen), 4'b0100);
        chk("nor_r2_lat", lat, 3);

        // Opcode sweep with r1 = F, r2 = 0
        issue(OP_NOR, 2'd1, 2'd0, 2'd0, wbd, en_seen, lat);
        for (int k = 0; k < 4; k++) begin
            issue(2'(k), 2'd3, 2'd1, 2'd2, wbd, en_seen, lat);
            chk("sweep_data", int'(wbd), int'(sweep_exp[k]));
            chk("sweep_en", int'(en_seen), int'(sweep_en[k]));
        end

        // Mid-cycle asynchronous reset while outputs are non-zero (in WB cycle)
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_op_en", int'(op_en), 0);
        chk("rst_op_a", int'(op_a), 0);
        chk("rst_op_b", int'(op_b), 0);
        chk("rst_wb_valid", int'(wb_valid), 0);
        chk("rst_wb_addr", int'(wb_addr), 0);
        chk("rst_wb_data", int'(wb_data), 0);
        chk("rst_busy", int'(busy), 0);
        @(posedge clk);
        model_update();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_ready", int'(instr_ready), 1);
        for (int a = 0; a < 4; a++) begin
            dbg_addr = 2'(a);
            #1;
            chk("rst_dbg", int'(dbg_data), 0);
            step();
        end

        // Hazard + handshake: second instruction held while busy
        instr_op = OP_NOR; instr_rd = 2'd1; instr_rs1 = 2'd0; instr_rs2 = 2'd0;
        instr_valid = 1'b1;
        wait_accept(a1);
        instr_op = OP_AND; instr_rd = 2'd2; instr_rs1 = 2'd1; instr_rs2 = 2'd1;
        wait_accept(a2);
        instr_valid = 1'b0;
        chk("hazard_gap", a2 - a1, 4);
        repeat (4) step();
        dbg_addr = 2'd2;
        #1;
        chk("hazard_r2", int'(dbg_data), 4'hF);

        // Reset during EXEC aborts the write-back
        instr_op = OP_XOR; instr_rd = 2'd3; instr_rs1 = 2'd1; instr_rs2 = 2'd0;
        instr_valid = 1'b1;
        wait_accept(a1);
        instr_valid = 1'b0;
        step();
        chk("exec_op_en", int'(op_en), 4'b1000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("exec_rst_op_en", int'(op_en), 0);
        chk("exec_rst_wb_valid", int'(wb_valid), 0);
        @(posedge clk);
        model_update();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) step();
        dbg_addr = 2'd3;
        #1;
        chk("exec_rst_rd", int'(dbg_data), 0);

        // Randomized traffic against the reference
        for (int i = 0; i < 800; i++) begin
            if (!instr_valid || accepted_now) begin
                instr_valid = 1'($urandom_range(0, 1));
                instr_op  = 2'($urandom_range(0, 3));
                instr_rd  = 2'($urandom_range(0, 3));
                instr_rs1 = 2'($urandom_range(0, 3));
                instr_rs2 = 2'($urandom_range(0, 3));
            end
            dbg_addr = 2'($urandom_range(0, 3));
            step();
        end
        instr_valid = 1'b0;
        repeat (6) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
